// File: rtl/demux_rr_sched16_pkg.sv
// Shared types and sizes for the 16-channel round-robin demux scheduler.
package demux_sched_pkg;

  localparam int N_CH  = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    DWELL = 2'd2
  } state_e;

endpackage

// File: rtl/demux_rr_sched16_if.sv
// Bundle between the upstream beat source / config and the round-robin scheduler.
interface demux_rr_sched16_if #(
  parameter int DWELL_W = 8
);
  import demux_sched_pkg::*;

  logic               en;
  logic [N_CH-1:0]    ch_mask;
  logic [DWELL_W-1:0] dwell;
  // Handshake: a beat transfers on a rising clk edge where in_valid && in_ready;
  // in_ready depends only on scheduler state and en, never on in_valid.
  logic               in_valid;
  logic               in_data;
  logic               in_ready;
  logic [SEL_W-1:0]   sel;
  logic [N_CH-1:0]    y;
  logic               busy;
  logic               ch_done;
  logic               frame_done;
  state_e             state;

  modport master (
    output en, ch_mask, dwell, in_valid, in_data,
    input  in_ready, sel, y, busy, ch_done, frame_done, state
  );

  modport slave (
    input  en, ch_mask, dwell, in_valid, in_data,
    output in_ready, sel, y, busy, ch_done, frame_done, state
  );

endinterface

// File: rtl/demux_rr_sched16_rr_next16.sv
// Circular next-set-bit search over a 16-bit mask, starting just after cur.
module rr_next16
  import demux_sched_pkg::*;
(
  input  logic [N_CH-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap,
  output logic             none
);

  logic [SEL_W-1:0] start;
  logic [N_CH-1:0]  rot;
  logic [SEL_W-1:0] off;

  always_comb begin
    start = cur + SEL_W'(1);
    // Rotate so bit 0 is channel cur+1, find the lowest set bit, rotate back.
    rot   = N_CH'({mask, mask} >> start);
    off   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
    nxt  = start + off;
    none = (mask == '0);
    wrap = !none && (nxt <= cur);
  end

endmodule

// File: rtl/demux_rr_sched16.sv
// Round-robin channel scheduler for a 1-to-16 serial demux: steps sel over enabled
// channels, holds each for dwell accepted beats, and drives registered gated outputs.
module demux_rr_sched16
  import demux_sched_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  demux_rr_sched16_if.slave  bus
);

  state_e             state;
  logic [SEL_W-1:0]   sel_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [N_CH-1:0]    y_q;
  logic [N_CH-1:0]    y_nxt;
  logic               ch_done_q;
  logic               frame_done_q;

  logic [SEL_W-1:0]   nxt;
  logic               wrap;
  logic               none;
  logic               in_ready;
  logic               accept;
  logic               last_beat;
  logic [DWELL_W-1:0] dwell_eff;

  rr_next16 u_next (
    .mask (bus.ch_mask),
    .cur  (sel_q),
    .nxt  (nxt),
    .wrap (wrap),
    .none (none)
  );

  // Dropping en closes the handshake in the same cycle, so no beat slips through.
  assign in_ready  = (state == DWELL) && bus.en;
  assign accept    = in_ready && bus.in_valid;
  assign dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
  assign last_beat = accept && ((cnt_q + DWELL_W'(1)) == dwell_eff);

  always_comb begin
    y_nxt = '0;
    if (accept) y_nxt[sel_q] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel_q        <= 4'hF;
      cnt_q        <= '0;
      y_q          <= '0;
      ch_done_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      y_q          <= y_nxt;
      ch_done_q    <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && (bus.ch_mask != '0)) state <= SEEK;
        end
        SEEK: begin
          if (!bus.en || none) begin
            state <= IDLE;
            cnt_q <= '0;
          end else begin
            // frame_done is registered, so it appears alongside the newly loaded sel.
            sel_q        <= nxt;
            cnt_q        <= '0;
            frame_done_q <= wrap;
            state        <= DWELL;
          end
        end
        DWELL: begin
          if (!bus.en) begin
            state <= IDLE;
            cnt_q <= '0;
          end else if (last_beat) begin
            cnt_q     <= '0;
            ch_done_q <= 1'b1;
            state     <= SEEK;
          end else if (accept) begin
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.sel        = sel_q;
  assign bus.y          = y_q;
  assign bus.busy       = (state != IDLE);
  assign bus.ch_done    = ch_done_q;
  assign bus.frame_done = frame_done_q;
  assign bus.state      = state;

endmodule
